// File: rtl/trigger_pkg.sv
// trigger_pkg: shared definitions for the sequential trigger output neuron.
// Holds the FSM state encoding, the configuration address map and the
// saturating-add helper used when TRIGGER_SAT_EN is defined.
package trigger_pkg;

    // FSM states: IDLE accepts a vector, MAC walks the taps, DONE presents the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Weights live at 0..n_in-1; the bias and threshold follow them.
    function automatic int bias_addr(input int n_in);
        return n_in;
    endfunction

    function automatic int thr_addr(input int n_in);
        return n_in + 1;
    endfunction

    // Adds two values that are already inside the acc_w signed range and clamps
    // the result to that range. Carried in 64 bits so any acc_w up to 63 works.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int              acc_w);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = $signed({a[63], a}) + $signed({b[63], b});
        hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
        lo = -hi - 65'sd1;
        if (s > hi) begin
            return hi[63:0];
        end else if (s < lo) begin
            return lo[63:0];
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/trigger_mac_unit.sv
// trigger_mac_unit: one multiply-accumulate step of the output neuron.
// term = (act * wt) >>> SHIFT (floor), sign-extended to the accumulator width,
// optionally followed by the bias add on the last tap.
// Build option: define TRIGGER_SAT_EN to clamp every add to the ACC_W range;
// otherwise the adds wrap in two's complement.
module trigger_mac_unit
    import trigger_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int W_W   = 8,
    parameter int ACC_W = 32,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]  act_i,
    input  logic signed [W_W-1:0]   wt_i,
    input  logic signed [W_W-1:0]   bias_i,
    input  logic                    add_bias_i,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int PROD_W = IN_W + W_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [ACC_W-1:0]  bias_ext;

    assign prod     = PROD_W'(act_i) * PROD_W'(wt_i);
    // Arithmetic shift rounds toward minus infinity, so -1*1 normalises to -1.
    assign shifted  = prod >>> SHIFT;
    assign bias_ext = {{(ACC_W-W_W){bias_i[W_W-1]}}, bias_i};

`ifdef TRIGGER_SAT_EN
    logic signed [63:0] acc64;
    logic signed [63:0] term64;
    logic signed [63:0] bias64;
    logic signed [63:0] sum_t;
    logic signed [63:0] sum_b;

    assign acc64  = {{(64-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign term64 = {{(64-PROD_W){shifted[PROD_W-1]}}, shifted};
    assign bias64 = {{(64-W_W){bias_i[W_W-1]}}, bias_i};

    // Clamp after the term add and again after the bias add.
    always_comb begin
        sum_t = sat_add(acc64, term64, ACC_W);
        sum_b = sum_t;
        if (add_bias_i) begin
            sum_b = sat_add(sum_t, bias64, ACC_W);
        end
        acc_o = sum_b[ACC_W-1:0];
    end
`else
    logic signed [ACC_W-1:0] term_ext;

    if (ACC_W > PROD_W) begin : g_ext
        assign term_ext = {{(ACC_W-PROD_W){shifted[PROD_W-1]}}, shifted};
    end else if (ACC_W == PROD_W) begin : g_same
        assign term_ext = shifted;
    end else begin : g_trunc
        assign term_ext = shifted[ACC_W-1:0];
    end

    // Plain wrap-around accumulate; bias joins on the final tap only.
    always_comb begin
        acc_o = acc_i + term_ext;
        if (add_bias_i) begin
            acc_o = acc_i + term_ext + bias_ext;
        end
    end
`endif

endmodule

// File: rtl/trigger_neuron_seq.sv
// trigger_neuron_seq: sequential L1-trigger output neuron.
// Accepts N_IN signed activations, accumulates one weighted term per clock on
// a shared multiplier, adds a bias and compares against a threshold.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; in_ready depends only on state, out_valid/score/trigger are registered
// and held unchanged while out_valid is high and out_ready is low.
// Build option: TRIGGER_SAT_EN selects saturating accumulation (see MAC unit).
module trigger_neuron_seq
    import trigger_pkg::*;
#(
    parameter  int N_IN   = 3,
    parameter  int IN_W   = 16,
    parameter  int W_W    = 8,
    parameter  int ACC_W  = 32,
    parameter  int SHIFT  = 7,
    localparam int ADDR_W = $clog2(N_IN + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*IN_W-1:0]     in_data,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [ACC_W-1:0]         cfg_wdata,
    output logic                     cfg_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  score,
    output logic                     trigger
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [N_IN*IN_W-1:0]     data_q, data_d;
    logic signed [ACC_W-1:0]  score_q, score_d;
    logic                     trig_q, trig_d;

    logic signed [W_W-1:0]    w_q [N_IN];
    logic signed [W_W-1:0]    bias_q;
    logic signed [ACC_W-1:0]  thr_q;

    logic                     last_tap;
    logic signed [IN_W-1:0]   act;
    logic signed [W_W-1:0]    wt;
    logic signed [ACC_W-1:0]  mac_acc;

    assign last_tap = (state_q == ST_MAC) && (idx_q == IDX_W'(N_IN - 1));
    assign act      = data_q[int'(idx_q)*IN_W +: IN_W];
    assign wt       = w_q[idx_q];

    trigger_mac_unit #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_mac (
        .act_i      (act),
        .wt_i       (wt),
        .bias_i     (bias_q),
        .add_bias_i (last_tap),
        .acc_i      (acc_q),
        .acc_o      (mac_acc)
    );

    // Next-state logic for the transaction FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        data_d  = data_q;
        score_d = score_q;
        trig_d  = trig_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = mac_acc;
                idx_d = idx_q + IDX_W'(1);
                if (last_tap) begin
                    score_d = mac_acc;
                    trig_d  = (mac_acc > thr_q);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset abandons any in-flight vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            score_q <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            score_q <= score_d;
            trig_q  <= trig_d;
        end
    end

    // Configuration register file; writes land only while IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
            bias_q <= '0;
            thr_q  <= '0;
        end else if (cfg_we && (state_q == ST_IDLE)) begin
            if (int'(cfg_addr) < N_IN) begin
                w_q[cfg_addr[IDX_W-1:0]] <= cfg_wdata[W_W-1:0];
            end else if (int'(cfg_addr) == bias_addr(N_IN)) begin
                bias_q <= cfg_wdata[W_W-1:0];
            end else if (int'(cfg_addr) == thr_addr(N_IN)) begin
                thr_q <= cfg_wdata;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign cfg_busy  = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign score     = score_q;
    assign trigger   = trig_q;

endmodule

// File: tb/tb_trigger_neuron_seq.sv
// tb_trigger_neuron_seq: directed and randomized checks of trigger_neuron_seq.
// A second instance with a 16-bit accumulator exercises wrap vs saturation
// (TRIGGER_SAT_EN).
module tb_trigger_neuron_seq;

  localparam int N_IN   = 3;
  localparam int IN_W   = 16;
  localparam int W_W    = 8;
  localparam int ACC_W  = 32;
  localparam int SHIFT  = 7;
  localparam int ADDR_W = $clog2(N_IN + 2);
  localparam int NACC_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic                    in_valid, in_ready, cfg_we, cfg_busy, out_valid, out_ready, trigger;
  logic [N_IN*IN_W-1:0]    in_data;
  logic [ADDR_W-1:0]       cfg_addr;
  logic [ACC_W-1:0]        cfg_wdata;
  logic signed [ACC_W-1:0] score;

  // narrow-accumulator instance
  logic                     n_in_valid, n_in_ready, n_cfg_we, n_cfg_busy, n_out_valid, n_out_ready, n_trigger;
  logic [N_IN*IN_W-1:0]     n_in_data;
  logic [ADDR_W-1:0]        n_cfg_addr;
  logic [NACC_W-1:0]        n_cfg_wdata;
  logic signed [NACC_W-1:0] n_score;

  trigger_neuron_seq #(.N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy),
    .out_valid(out_valid), .out_ready(out_ready), .score(score), .trigger(trigger)
  );

  trigger_neuron_seq #(.N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .ACC_W(NACC_W), .SHIFT(SHIFT)) dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .cfg_we(n_cfg_we), .cfg_addr(n_cfg_addr), .cfg_wdata(n_cfg_wdata), .cfg_busy(n_cfg_busy),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .score(n_score), .trigger(n_trigger)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [ACC_W:0] exp_q[$];   // {trigger, score}

  // reference configuration
  longint w_m[N_IN];
  longint b_m;
  longint thr_m;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fold(input longint v, input int acc_w);
    longint m;
    longint r;
`ifdef TRIGGER_SAT_EN
    m = (longint'(1) <<< (acc_w - 1)) - 1;
    r = v;
    if (v > m) r = m;
    if (v < -m - 1) r = -m - 1;
`else
    m = longint'(1) <<< acc_w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
`endif
    return r;
  endfunction

  function automatic longint model_score(input longint a[N_IN], input int acc_w);
    longint acc;
    acc = 0;
    for (int i = 0; i < N_IN; i++) begin
      acc = fold(acc + ((a[i] * w_m[i]) >>> SHIFT), acc_w);
    end
    return fold(acc + b_m, acc_w);
  endfunction

  function automatic void model_cfg(input int addr, input logic [ACC_W-1:0] d);
    if (addr < N_IN) w_m[addr] = longint'($signed(d[W_W-1:0]));
    else if (addr == N_IN) b_m = longint'($signed(d[W_W-1:0]));
    else if (addr == N_IN + 1) thr_m = longint'($signed(d));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_IN; i++) w_m[i] = 0;
    b_m = 0;
    thr_m = 0;
  endfunction

  function automatic logic [N_IN*IN_W-1:0] pack(input longint a[N_IN]);
    logic [N_IN*IN_W-1:0] v;
    longint x;
    for (int i = 0; i < N_IN; i++) begin
      x = a[i];
      v[i*IN_W +: IN_W] = x[IN_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] rand_cfg(input int addr);
    int t;
    if (addr == N_IN + 1) begin
      t = int'($urandom_range(0, 6000)) - 3000;
      return ACC_W'(t);
    end
    return {24'($urandom), 8'($urandom_range(0, 255))};
  endfunction

  task automatic push_exp(input longint a[N_IN]);
    longint s;
    s = model_score(a, ACC_W);
    exp_q.push_back({(s > thr_m), s[ACC_W-1:0]});
  endtask

  task automatic push_const(input longint s, input logic t);
    exp_q.push_back({t, s[ACC_W-1:0]});
  endtask

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic cfg_write(input int addr, input logic [ACC_W-1:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = ADDR_W'(addr);
    cfg_wdata = data;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic send(input logic [N_IN*IN_W-1:0] v, input bit with_cfg, input int caddr,
                      input logic [ACC_W-1:0] cdata);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = v;
    if (with_cfg) begin
      cfg_we    = 1'b1;
      cfg_addr  = ADDR_W'(caddr);
      cfg_wdata = cdata;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic get_result(output int lat);
    logic [ACC_W:0] e;
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      chk("result_timeout", 0, 1);
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("score", score, $signed(e[ACC_W-1:0]));
      chk("trigger", trigger, e[ACC_W]);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  longint va[N_IN];
  longint vb[N_IN];
  longint vr[N_IN];
  int lat;
  int n;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_cfg_we = 1'b0; n_cfg_addr = '0; n_cfg_wdata = '0; n_out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_score", score, 0);
    chk("rst_trigger", trigger, 0);

    // basic vector: terms 128, -32, -64, bias 5
    va = '{256, 128, -512};
    cfg_write(0, 32'd64);
    cfg_write(1, -32'sd32);
    cfg_write(2, 32'd16);
    cfg_write(3, 32'd5);
    cfg_write(4, 32'd0);
    push_const(37, 1'b1);
    send(pack(va), 0, 0, '0);
    chk("mac_in_ready", in_ready, 0);
    chk("mac_cfg_busy", cfg_busy, 1);
    get_result(lat);
    chk("latency", lat, N_IN);

    // threshold equal to score gives no trigger
    cfg_write(4, 32'd37);
    push_const(37, 1'b0);
    send(pack(va), 0, 0, '0);
    get_result(lat);

    // floor of a negative product
    vb = '{-1, 0, 0};
    cfg_write(0, 32'd1);
    cfg_write(3, 32'd0);
    cfg_write(4, 32'd0);
    push_const(-1, 1'b0);
    send(pack(vb), 0, 0, '0);
    get_result(lat);

    // backpressure: hold result 5 cycles while a new vector waits
    cfg_write(0, 32'd64);
    cfg_write(3, 32'd5);
    push_const(37, 1'b1);
    push_const(4, 1'b1);      // -1*64 floors to -1, plus bias 5
    send(pack(va), 0, 0, '0);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = pack(vb);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_score", score, 37);
      chk("hold_trigger", trigger, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    get_result(lat);
    chk("post_handshake_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("second_accepted", cfg_busy, 1);
    get_result(lat);

    // write to weight 0 during MAC is dropped
    push_const(37, 1'b1);
    send(pack(va), 0, 0, '0);
    cfg_write(0, 32'd0);
    get_result(lat);
    // same write while IDLE takes effect
    cfg_write(0, 32'd0);
    push_const(-91, 1'b0);
    send(pack(va), 0, 0, '0);
    get_result(lat);
    // write coincident with acceptance is seen by that vector
    push_const(37, 1'b1);
    send(pack(va), 1, 0, 32'd64);
    get_result(lat);

    // out-of-range addresses change nothing
    for (int a = N_IN + 2; a < (1 << ADDR_W); a++) cfg_write(a, 32'h7FFF_FF80);
    push_const(37, 1'b1);
    send(pack(va), 0, 0, '0);
    get_result(lat);

    // asynchronous reset in the second MAC cycle
    send(pack(va), 0, 0, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("amid_in_ready", in_ready, 1);
    chk("amid_out_valid", out_valid, 0);
    chk("amid_score", score, 0);
    chk("amid_trigger", trigger, 0);
    chk("amid_cfg_busy", cfg_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    push_const(0, 1'b0);
    send(pack(va), 0, 0, '0);
    get_result(lat);

    // randomized traffic against the reference model
    for (int t = 0; t < 25; t++) begin
      int caddr;
      bit coinc;
      logic [ACC_W-1:0] cd;
      for (int a = 0; a < N_IN + 2; a++) begin
        if ($urandom_range(0, 1) == 1) begin
          cd = rand_cfg(a);
          cfg_write(a, cd);
          model_cfg(a, cd);
        end
      end
      if ($urandom_range(0, 4) == 0)
        cfg_write(int'($urandom_range(N_IN + 2, (1 << ADDR_W) - 1)), $urandom);
      for (int i = 0; i < N_IN; i++) begin
        if ($urandom_range(0, 1) == 1) vr[i] = longint'(int'($urandom_range(0, 1200)) - 600);
        else vr[i] = longint'($signed(16'($urandom)));
      end
      coinc = ($urandom_range(0, 3) == 0);
      caddr = int'($urandom_range(0, N_IN + 1));
      cd    = rand_cfg(caddr);
      if (coinc) model_cfg(caddr, cd);
      push_exp(vr);
      send(pack(vr), coinc, caddr, cd);
      if ($urandom_range(0, 2) == 0) begin
        caddr = int'($urandom_range(0, N_IN + 1));
        cfg_write(caddr, rand_cfg(caddr));   // lands while busy: dropped
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      get_result(lat);
    end

    // narrow accumulator: 3 * 32511 overflows 16 bits
    for (int a = 0; a < N_IN; a++) begin
      @(negedge clk);
      n_cfg_we    = 1'b1;
      n_cfg_addr  = ADDR_W'(a);
      n_cfg_wdata = 16'd127;
    end
    @(negedge clk);
    n_cfg_we   = 1'b0;
    n_in_valid = 1'b1;
    n_in_data  = {N_IN{16'h7FFF}};
    @(negedge clk);
    n_in_valid  = 1'b0;
    n_out_ready = 1'b1;
    n = 0;
    while (!n_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!n_out_valid) begin
      chk("narrow_timeout", 0, 1);
    end else begin
`ifdef TRIGGER_SAT_EN
      chk("narrow_score", n_score, 32767);
`else
      chk("narrow_score", n_score, 31997);
`endif
      chk("narrow_trigger", n_trigger, 1);
    end
    @(negedge clk);
    n_out_ready = 1'b0;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
